// File: rtl/axi_sram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_if
//   Channel bundle between a load/store AXI-subset master and the SRAM
//   responder. Single-beat only: no burst, id or response-code fields.
//
//   AW: AW_ADDR[63:0], AW_VALID, AW_READY   write byte address
//   W : W_DATA[63:0], W_STRB[7:0], W_VALID, W_READY
//   B : B_VALID, B_READY                    write completion
//   AR: AR_ADDR[63:0], AR_VALID, AR_READY   read byte address
//   R : R_DATA[63:0], R_VALID, R_READY      read data
//
//   modport slave  : the memory side (drives READYs on AW/W/AR, B, R)
//   modport master : the requester side
// ---------------------------------------------------------------------------
interface axi_sram_slave_if;
  logic [63:0] AW_ADDR;
  logic        AW_VALID;
  logic        AW_READY;
  logic [63:0] W_DATA;
  logic [7:0]  W_STRB;
  logic        W_VALID;
  logic        W_READY;
  logic        B_VALID;
  logic        B_READY;
  logic [63:0] AR_ADDR;
  logic        AR_VALID;
  logic        AR_READY;
  logic [63:0] R_DATA;
  logic        R_VALID;
  logic        R_READY;

  modport slave (
    input  AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY,
           AR_ADDR, AR_VALID, R_READY,
    output AW_READY, W_READY, B_VALID, AR_READY, R_DATA, R_VALID
  );

  modport master (
    output AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY,
           AR_ADDR, AR_VALID, R_READY,
    input  AW_READY, W_READY, B_VALID, AR_READY, R_DATA, R_VALID
  );
endinterface

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   Single-beat AXI-subset responder in front of a word-addressed 64-bit
//   SRAM. Used as simulation memory and as the on-chip scratchpad behind
//   the data port. Independent write (AW/W/B) and read (AR/R) engines.
//
//   Parameters
//     DEPTH     : number of 64-bit words (power of 2)
//     BASE_ADDR : byte address of word 0
//     LATENCY   : wait cycles between capture and B_VALID / R_VALID (0..15)
//
//   Ports
//     clk   : clock
//     rst_n : asynchronous active-low reset (array contents are kept)
//     axi   : axi_sram_slave_if.slave channel bundle
//
//   Optional build macro
//     AXI_SRAM_SLAVE_STALL_EN : when defined, an 8-bit LFSR randomly masks
//     AW_READY / W_READY / AR_READY to exercise master back-pressure.
// ---------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int          DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_sram_slave_if.slave  axi
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  // Storage (not reset)
  logic [63:0] mem [DEPTH];

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  // Low three address bits are byte-in-word and play no part in indexing.
  function automatic logic [IDX_W-1:0] to_idx(input logic [63:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  // -------------------------------------------------------------------------
  // Ready masking
  // -------------------------------------------------------------------------
  logic stall;

`ifdef AXI_SRAM_SLAVE_STALL_EN
  logic [7:0] lfsr_reg;

  // Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= 8'hA5;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  assign stall = lfsr_reg[0];
`else
  assign stall = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Write engine
  // -------------------------------------------------------------------------
  w_state_t    w_state_reg;
  logic        aw_got_reg, w_got_reg;
  logic        aw_ready_reg, w_ready_reg, b_valid_reg;
  logic [3:0]  w_cnt_reg;
  logic [63:0] aw_addr_reg;
  logic [63:0] w_data_reg;
  logic [7:0]  w_strb_reg;

  logic        aw_hs, w_hs, both_got;
  logic        commit_fire;
  logic        commit_en;
  logic [63:0] commit_addr;
  logic [63:0] commit_data;
  logic [7:0]  commit_strb;
  logic [7:0]  lane_we;

  assign axi.AW_READY = aw_ready_reg & ~stall;
  assign axi.W_READY  = w_ready_reg  & ~stall;
  assign axi.B_VALID  = b_valid_reg;

  assign aw_hs    = axi.AW_VALID & axi.AW_READY;
  assign w_hs     = axi.W_VALID  & axi.W_READY;
  assign both_got = (aw_got_reg | aw_hs) & (w_got_reg | w_hs);

  // The commit happens on the edge that moves the engine into W_RESP. With
  // zero latency that edge may also be the handshake edge, so the fresh bus
  // values bypass the capture registers.
  always_comb begin
    commit_fire = 1'b0;
    commit_addr = aw_hs ? axi.AW_ADDR : aw_addr_reg;
    commit_data = w_hs  ? axi.W_DATA  : w_data_reg;
    commit_strb = w_hs  ? axi.W_STRB  : w_strb_reg;
    case (w_state_reg)
      W_IDLE:  commit_fire = (LATENCY == 0) && both_got;
      W_WAIT:  commit_fire = (w_cnt_reg == 4'd1);
      default: commit_fire = 1'b0;
    endcase
  end

  // Out-of-range writes still complete on B; they simply never reach the
  // array. rst_n gating keeps a write from landing while reset is held.
  assign commit_en = rst_n & commit_fire & in_range(commit_addr);

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign lane_we[gi] = commit_en & commit_strb[gi];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (lane_we[i]) begin
        mem[to_idx(commit_addr)][i*8 +: 8] <= commit_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg  <= W_IDLE;
      aw_got_reg   <= 1'b0;
      w_got_reg    <= 1'b0;
      aw_ready_reg <= 1'b1;
      w_ready_reg  <= 1'b1;
      b_valid_reg  <= 1'b0;
      w_cnt_reg    <= 4'd0;
      aw_addr_reg  <= 64'd0;
      w_data_reg   <= 64'd0;
      w_strb_reg   <= 8'd0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_reg <= axi.AW_ADDR;
            aw_got_reg  <= 1'b1;
          end
          if (w_hs) begin
            w_data_reg <= axi.W_DATA;
            w_strb_reg <= axi.W_STRB;
            w_got_reg  <= 1'b1;
          end
          if (both_got) begin
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b0;
            if (LATENCY == 0) begin
              w_state_reg <= W_RESP;
              b_valid_reg <= 1'b1;
            end else begin
              w_state_reg <= W_WAIT;
              w_cnt_reg   <= LAT;
            end
          end else begin
            aw_ready_reg <= ~(aw_got_reg | aw_hs);
            w_ready_reg  <= ~(w_got_reg  | w_hs);
          end
        end
        W_WAIT: begin
          if (w_cnt_reg == 4'd1) begin
            w_state_reg <= W_RESP;
            b_valid_reg <= 1'b1;
            w_cnt_reg   <= 4'd0;
          end else begin
            w_cnt_reg <= w_cnt_reg - 4'd1;
          end
        end
        W_RESP: begin
          if (axi.B_READY) begin
            w_state_reg  <= W_IDLE;
            b_valid_reg  <= 1'b0;
            aw_got_reg   <= 1'b0;
            w_got_reg    <= 1'b0;
            aw_ready_reg <= 1'b1;
            w_ready_reg  <= 1'b1;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read engine
  // -------------------------------------------------------------------------
  r_state_t    r_state_reg;
  logic        ar_ready_reg, r_valid_reg;
  logic [3:0]  r_cnt_reg;
  logic [63:0] ar_addr_reg;
  logic [63:0] r_data_reg;
  logic        ar_hs;

  assign axi.AR_READY = ar_ready_reg & ~stall;
  assign axi.R_VALID  = r_valid_reg;
  assign axi.R_DATA   = r_data_reg;
  assign ar_hs        = axi.AR_VALID & axi.AR_READY;

  // Non-blocking array semantics give "old data" when a read samples the
  // same word on the edge a write commits.
  function automatic logic [63:0] rd_word(input logic [63:0] a);
    return in_range(a) ? mem[to_idx(a)] : 64'd0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_reg  <= R_IDLE;
      ar_ready_reg <= 1'b1;
      r_valid_reg  <= 1'b0;
      r_cnt_reg    <= 4'd0;
      ar_addr_reg  <= 64'd0;
      r_data_reg   <= 64'd0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            ar_addr_reg  <= axi.AR_ADDR;
            ar_ready_reg <= 1'b0;
            if (LATENCY == 0) begin
              r_state_reg <= R_RESP;
              r_valid_reg <= 1'b1;
              r_data_reg  <= rd_word(axi.AR_ADDR);
            end else begin
              r_state_reg <= R_WAIT;
              r_cnt_reg   <= LAT;
            end
          end
        end
        R_WAIT: begin
          if (r_cnt_reg == 4'd1) begin
            r_state_reg <= R_RESP;
            r_valid_reg <= 1'b1;
            r_data_reg  <= rd_word(ar_addr_reg);
            r_cnt_reg   <= 4'd0;
          end else begin
            r_cnt_reg <= r_cnt_reg - 4'd1;
          end
        end
        R_RESP: begin
          if (axi.R_READY) begin
            r_state_reg  <= R_IDLE;
            r_valid_reg  <= 1'b0;
            ar_ready_reg <= 1'b1;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//   Self-checking bench for axi_sram_slave (LATENCY = 1). A word-level
//   reference memory (associative array) predicts every read; directed
//   scenarios cover ordering, back-pressure, range edges, concurrency and
//   reset abort, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

  localparam int          DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          LAT   = 1;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;

  axi_sram_slave_if axi ();

  axi_sram_slave #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .LATENCY   (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axi   (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // Ready-mask prediction
  // -------------------------------------------------------------------------
  logic m_stall;
`ifdef AXI_SRAM_SLAVE_STALL_EN
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
  assign m_stall = m_lfsr[0];

  always @(negedge clk) begin
    if (rst_n && m_stall && (axi.AW_VALID || axi.W_VALID || axi.AR_VALID)) begin
      tests++;
      if ((axi.AW_VALID && axi.AW_READY) || (axi.W_VALID && axi.W_READY) ||
          (axi.AR_VALID && axi.AR_READY)) begin
        fails++;
        $display("FAIL stall_mask cycle=%0d handshake while lfsr[0]=1", cyc);
      end
    end
  end
`else
  assign m_stall = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Reference memory
  // -------------------------------------------------------------------------
  logic [63:0] ref_mem [int];

  function automatic bit m_in_range(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < 64'(DEPTH) * 64'd8);
  endfunction

  function automatic int m_idx(input logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  task automatic m_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] w;
    if (m_in_range(a)) begin
      w = ref_mem.exists(m_idx(a)) ? ref_mem[m_idx(a)] : 64'hx;
      for (int b = 0; b < 8; b++)
        if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
      ref_mem[m_idx(a)] = w;
    end
  endtask

  function automatic logic [63:0] m_read(input logic [63:0] a);
    if (!m_in_range(a)) return 64'd0;
    return ref_mem.exists(m_idx(a)) ? ref_mem[m_idx(a)] : 64'hx;
  endfunction

  // -------------------------------------------------------------------------
  // Bus drivers (called between edges). lat = cycles from handshake cycle
  // to the cycle where B_VALID / R_VALID is first seen.
  // -------------------------------------------------------------------------
  task automatic wr(input logic [63:0] addr, input logic [63:0] data,
                    input logic [7:0] strb, input int bhold, output int lat);
    bit aw_ok, w_ok, a_now, w_now;
    int n, hs;
    aw_ok = 0; w_ok = 0; n = 0; hs = 0; lat = -1;
    axi.AW_ADDR = addr; axi.AW_VALID = 1'b1;
    axi.W_DATA = data; axi.W_STRB = strb; axi.W_VALID = 1'b1;
    while (!(aw_ok && w_ok) && n < 100) begin
      @(negedge clk);
      a_now = axi.AW_VALID && axi.AW_READY;
      w_now = axi.W_VALID && axi.W_READY;
      if (a_now || w_now) hs = cyc;
      @(posedge clk); #1;
      if (a_now) begin aw_ok = 1; axi.AW_VALID = 1'b0; end
      if (w_now) begin w_ok = 1; axi.W_VALID = 1'b0; end
      n++;
    end
    if (!(aw_ok && w_ok)) begin
      tests++; fails++;
      $display("FAIL wr_handshake addr=%h got aw=%0b w=%0b want both", addr, aw_ok, w_ok);
      axi.AW_VALID = 1'b0; axi.W_VALID = 1'b0;
      return;
    end
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (axi.B_VALID) break;
      n++;
    end
    if (!axi.B_VALID) begin
      tests++; fails++;
      $display("FAIL wr_bvalid addr=%h got timeout want B_VALID", addr);
      return;
    end
    lat = cyc - hs;
    repeat (bhold) begin
      @(negedge clk);
      tests++;
      if (axi.B_VALID !== 1'b1 || axi.AW_READY !== 1'b0 || axi.W_READY !== 1'b0) begin
        fails++;
        $display("FAIL b_hold got bv=%b awr=%b wr=%b want 1 0 0",
                 axi.B_VALID, axi.AW_READY, axi.W_READY);
      end
    end
    axi.B_READY = 1'b1;
    @(posedge clk); #1;
    axi.B_READY = 1'b0;
  endtask

  task automatic rd(input logic [63:0] addr, input int rhold,
                    output logic [63:0] data, output int lat);
    bit ok;
    int n, hs;
    ok = 0; n = 0; hs = 0; lat = -1; data = 64'd0;
    axi.AR_ADDR = addr; axi.AR_VALID = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (axi.AR_VALID && axi.AR_READY) begin ok = 1; hs = cyc; end
      @(posedge clk); #1;
      if (ok) axi.AR_VALID = 1'b0;
      n++;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL rd_handshake addr=%h got timeout want AR handshake", addr);
      axi.AR_VALID = 1'b0;
      return;
    end
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (axi.R_VALID) break;
      n++;
    end
    if (!axi.R_VALID) begin
      tests++; fails++;
      $display("FAIL rd_rvalid addr=%h got timeout want R_VALID", addr);
      return;
    end
    lat  = cyc - hs;
    data = axi.R_DATA;
    repeat (rhold) begin
      @(negedge clk);
      tests++;
      if (axi.R_VALID !== 1'b1 || axi.R_DATA !== data) begin
        fails++;
        $display("FAIL r_hold got rv=%b data=%h want 1 %h", axi.R_VALID, axi.R_DATA, data);
      end
    end
    axi.R_READY = 1'b1;
    @(posedge clk); #1;
    axi.R_READY = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (axi.AW_READY !== !m_stall || axi.W_READY !== !m_stall || axi.AR_READY !== !m_stall ||
        axi.B_VALID !== 1'b0 || axi.R_VALID !== 1'b0 || axi.R_DATA !== 64'd0) begin
      fails++;
      $display("FAIL reset_state got awr=%b wr=%b arr=%b bv=%b rv=%b rd=%h want rdy=%b bv=0 rv=0 rd=0",
               axi.AW_READY, axi.W_READY, axi.AR_READY, axi.B_VALID, axi.R_VALID, axi.R_DATA, !m_stall);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("[TB] reset released");
  endtask

  task automatic test_basic();
    logic [63:0] d;
    int lat;
    wr(64'h8000_0010, 64'h1122334455667788, 8'hFF, 0, lat);
    m_write(64'h8000_0010, 64'h1122334455667788, 8'hFF);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL basic_b_latency got %0d want 2", lat); end
    rd(64'h8000_0010, 0, d, lat);
    tests++;
    if (d !== 64'h1122334455667788 || lat !== 2) begin
      fails++;
      $display("FAIL basic_read got data=%h lat=%0d want 1122334455667788 2", d, lat);
    end
    $display("[TB] basic write/read data=%h", d);
  endtask

  task automatic test_strobe();
    logic [63:0] a, d;
    int lat;
    a = BASE + 64'h40;
    wr(a, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, lat); m_write(a, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(a, 64'h0000_0000_0000_00AB, 8'h01, 0, lat); m_write(a, 64'h0000_0000_0000_00AB, 8'h01);
    rd(a, 0, d, lat);
    tests++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFAB || d !== m_read(a)) begin
      fails++; $display("FAIL strobe_01 got %h want FFFFFFFFFFFFFFAB", d);
    end
    wr(a, 64'h0000_0000_1234_5678, 8'h0F, 0, lat); m_write(a, 64'h0000_0000_1234_5678, 8'h0F);
    rd(a, 0, d, lat);
    tests++;
    if (d !== 64'hFFFF_FFFF_1234_5678 || d !== m_read(a)) begin
      fails++; $display("FAIL strobe_0F got %h want FFFFFFFF12345678", d);
    end
    $display("[TB] strobe readback %h", d);
  endtask

  task automatic test_w_before_aw();
    logic [63:0] a, d;
    int lat;
    a = BASE + 64'h100;
    wr(a, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 0, lat); m_write(a, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF);
    axi.W_DATA = 64'hCAFE_F00D_DEAD_BEEF; axi.W_STRB = 8'hFF; axi.W_VALID = 1'b1;
    @(negedge clk);
    tests++;
    if (axi.W_READY !== 1'b1) begin fails++; $display("FAIL wfirst_wready got %b want 1", axi.W_READY); end
    @(posedge clk); #1; axi.W_VALID = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (axi.W_READY !== 1'b0 || axi.AW_READY !== 1'b1 || axi.B_VALID !== 1'b0) begin
        fails++;
        $display("FAIL wfirst_gap got wr=%b awr=%b bv=%b want 0 1 0", axi.W_READY, axi.AW_READY, axi.B_VALID);
      end
      @(posedge clk); #1;
    end
    axi.AW_ADDR = a; axi.AW_VALID = 1'b1;
    @(negedge clk);
    tests++;
    if (axi.AW_READY !== 1'b1 || axi.B_VALID !== 1'b0) begin
      fails++; $display("FAIL wfirst_aw got awr=%b bv=%b want 1 0", axi.AW_READY, axi.B_VALID);
    end
    @(posedge clk); #1; axi.AW_VALID = 1'b0;
    @(negedge clk);
    tests++;
    if (axi.B_VALID !== 1'b0 || axi.AW_READY !== 1'b0) begin
      fails++; $display("FAIL wfirst_wait got bv=%b awr=%b want 0 0", axi.B_VALID, axi.AW_READY);
    end
    repeat (5) begin
      @(negedge clk);
      tests++;
      if (axi.B_VALID !== 1'b1 || axi.AW_READY !== 1'b0) begin
        fails++; $display("FAIL wfirst_bhold got bv=%b awr=%b want 1 0", axi.B_VALID, axi.AW_READY);
      end
    end
    axi.B_READY = 1'b1;
    @(posedge clk); #1; axi.B_READY = 1'b0;
    m_write(a, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
    @(negedge clk);
    tests++;
    if (axi.AW_READY !== 1'b1 || axi.W_READY !== 1'b1 || axi.B_VALID !== 1'b0) begin
      fails++;
      $display("FAIL wfirst_release got awr=%b wr=%b bv=%b want 1 1 0", axi.AW_READY, axi.W_READY, axi.B_VALID);
    end
    @(posedge clk); #1;
    rd(a, 0, d, lat);
    tests++;
    if (d !== m_read(a)) begin fails++; $display("FAIL wfirst_data got %h want %h", d, m_read(a)); end
    $display("[TB] W-before-AW write data=%h", d);
  endtask

  task automatic test_out_of_range();
    logic [63:0] d, top;
    int lat;
    wr(64'h7FFF_FFF8, 64'h5555_AAAA_5555_AAAA, 8'hFF, 0, lat);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL oor_write_b got lat=%0d want 2", lat); end
    rd(64'h7FFF_FFF8, 0, d, lat);
    tests++;
    if (d !== 64'd0) begin fails++; $display("FAIL oor_low_read got %h want 0", d); end
    top = BASE + 64'(DEPTH) * 64'd8;
    rd(top, 0, d, lat);
    tests++;
    if (d !== 64'd0) begin fails++; $display("FAIL oor_high_read got %h want 0", d); end
    wr(top - 64'd8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, lat);
    m_write(top - 64'd8, 64'h0123_4567_89AB_CDEF, 8'hFF);
    rd(top - 64'd8, 0, d, lat);
    tests++;
    if (d !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL last_word got %h want 0123456789abcdef", d); end
    $display("[TB] out-of-range checks done");
  endtask

  task automatic test_concurrent();
    logic [63:0] a, d, old_v;
    int wl, rl;
    a = BASE + 64'd32;   // idx 4
    wr(a, 64'h1111_2222_3333_4444, 8'hFF, 0, wl); m_write(a, 64'h1111_2222_3333_4444, 8'hFF);
    old_v = m_read(a);
    fork
      wr(a, 64'h9999_8888_7777_6666, 8'hFF, 0, wl);
      rd(a, 4, d, rl);
    join
    tests++;
    if (d !== old_v) begin fails++; $display("FAIL concurrent_old got %h want %h", d, old_v); end
    m_write(a, 64'h9999_8888_7777_6666, 8'hFF);
    rd(a, 0, d, rl);
    tests++;
    if (d !== m_read(a)) begin fails++; $display("FAIL concurrent_new got %h want %h", d, m_read(a)); end
    $display("[TB] concurrent read old=%h new=%h", old_v, d);
  endtask

  task automatic test_reset_abort();
    logic [63:0] a, d;
    int lat;
    a = BASE + 64'h200;
    wr(a, 64'h7777_7777_7777_7777, 8'hFF, 0, lat); m_write(a, 64'h7777_7777_7777_7777, 8'hFF);
    axi.AW_ADDR = a; axi.AW_VALID = 1'b1;
    axi.W_DATA = 64'hDEAD_DEAD_DEAD_DEAD; axi.W_STRB = 8'hFF; axi.W_VALID = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    axi.AW_VALID = 1'b0; axi.W_VALID = 1'b0;
    rst_n = 1'b0;             // engine is in the wait state now
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (axi.B_VALID !== 1'b0 || axi.AW_READY !== 1'b1 || axi.W_READY !== 1'b1 || axi.AR_READY !== 1'b1) begin
        fails++;
        $display("FAIL abort_state got bv=%b awr=%b wr=%b arr=%b want 0 1 1 1",
                 axi.B_VALID, axi.AW_READY, axi.W_READY, axi.AR_READY);
      end
    end
    @(posedge clk); #1;
    rd(a, 0, d, lat);
    tests++;
    if (d !== m_read(a)) begin fails++; $display("FAIL abort_data got %h want %h", d, m_read(a)); end
    $display("[TB] reset abort word=%h", d);
  endtask

  task automatic test_random();
    logic [63:0] pool [8];
    logic [63:0] a, d, e, wd;
    logic [7:0]  s;
    int lat;
    pool[0] = BASE;
    pool[7] = BASE + 64'(DEPTH - 1) * 64'd8;
    for (int i = 1; i < 7; i++) pool[i] = BASE + 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
    for (int i = 0; i < 8; i++) begin
      wd = {$urandom, $urandom};
      wr(pool[i], wd, 8'hFF, 0, lat);
      m_write(pool[i], wd, 8'hFF);
    end
    for (int i = 0; i < 100; i++) begin
      a = pool[$urandom_range(0, 7)] + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = BASE - 64'd8 * 64'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        wd = {$urandom, $urandom};
        s  = 8'($urandom_range(0, 255));
        wr(a, wd, s, $urandom_range(0, 2), lat);
        m_write(a, wd, s);
        $display("[TB] rnd %0d WR addr=%h data=%h strb=%h", i, a, wd, s);
      end else begin
        e = m_read(a);
        rd(a, $urandom_range(0, 2), d, lat);
        tests++;
        if (d !== e) begin fails++; $display("FAIL rnd_read addr=%h got %h want %h", a, d, e); end
        $display("[TB] rnd %0d RD addr=%h data=%h", i, a, d);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    axi.AW_ADDR = '0; axi.AW_VALID = 1'b0;
    axi.W_DATA = '0; axi.W_STRB = '0; axi.W_VALID = 1'b0;
    axi.B_READY = 1'b0;
    axi.AR_ADDR = '0; axi.AR_VALID = 1'b0;
    axi.R_READY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
`ifndef AXI_SRAM_SLAVE_STALL_EN
    test_basic();
    test_strobe();
    test_w_before_aw();
    test_out_of_range();
    test_concurrent();
    test_reset_abort();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got time limit want completion");
    $fatal(1, "watchdog");
  end

endmodule
